// File: rtl/sti_rx_deser.sv
// STI serial receiver: rebuilds 8/16/24/32-bit frames and extracts the 16-bit payload.
// Define STI_RX_PADCHK_EN to build the non-payload (pad) bit check that drives pad_err.
module sti_rx_deser #(
  parameter int GAP_TOL     = 0,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   si_data,
  input  logic                   si_valid,
  input  logic                   si_end,
  input  logic [1:0]             cfg_length,
  input  logic                   cfg_fill,
  input  logic                   cfg_msb,
  input  logic                   cfg_low,
  output logic [15:0]            po_data,
  output logic                   po_valid,
  output logic                   frame_err,
  output logic                   pad_err,
  output logic                   rx_busy,
  output logic                   rx_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [4:0] TOL = 5'(GAP_TOL);

  state_t      state;
  logic [31:0] frame, fr_nxt;
  logic [5:0]  cnt, cnt_nxt, flen;
  logic [4:0]  gap, gap_nxt;
  logic [1:0]  sh_len, a_len;
  logic        sh_fill, sh_msb, sh_low;
  logic        a_fill, a_msb, a_low;
  logic        idle;
  logic [15:0] pay;

  assign idle = (state == IDLE);

  // The first bit of a frame uses live cfg_*, later bits use the shadows
  always_comb begin
    a_len   = idle ? cfg_length : sh_len;
    a_fill  = idle ? cfg_fill   : sh_fill;
    a_msb   = idle ? cfg_msb    : sh_msb;
    a_low   = idle ? cfg_low    : sh_low;
    fr_nxt  = idle ? 32'd0 : frame;
    if (a_msb)
      fr_nxt = {fr_nxt[30:0], si_data};
    else
      fr_nxt[cnt[4:0]] = si_data;
    cnt_nxt = cnt + 6'd1;
    flen    = {1'b0, a_len, 3'b000} + 6'd8;
    gap_nxt = gap + 5'd1;
    pay     = 16'h0000;
    unique case (a_len)
      2'd0: pay = a_low ? {fr_nxt[7:0], 8'h00}
                        : {8'h00, fr_nxt[7:0]};
      2'd1: pay = fr_nxt[15:0];
      2'd2: pay = a_fill ? fr_nxt[23:8]
                         : fr_nxt[15:0];
      2'd3: pay = a_fill ? fr_nxt[31:16]
                         : fr_nxt[15:0];
    endcase
  end

`ifdef STI_RX_PADCHK_EN
  logic pad_bad;

  always_comb begin
    pad_bad = 1'b0;
    unique case (a_len)
      2'd2: pad_bad = a_fill ? |fr_nxt[7:0]
                             : |fr_nxt[23:16];
      2'd3: pad_bad = a_fill ? |fr_nxt[15:0]
                             : |fr_nxt[31:16];
      default: pad_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pad_err <= 1'b0;
    else
      pad_err <= (state == RECV) && si_valid
                 && (cnt_nxt == flen) && pad_bad;
  end
`else
  assign pad_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      frame     <= 32'd0;
      cnt       <= 6'd0;
      gap       <= 5'd0;
      sh_len    <= 2'd0;
      sh_fill   <= 1'b0;
      sh_msb    <= 1'b0;
      sh_low    <= 1'b0;
      po_data   <= 16'h0000;
      po_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
      rx_done   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      po_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (si_valid) begin
            sh_len  <= cfg_length;
            sh_fill <= cfg_fill;
            sh_msb  <= cfg_msb;
            sh_low  <= cfg_low;
            frame   <= fr_nxt;
            cnt     <= 6'd1;
            gap     <= 5'd0;
            rx_busy <= 1'b1;
            state   <= RECV;
          end
        end
        RECV: begin
          if (si_valid) begin
            gap <= 5'd0;
            if (cnt_nxt == flen) begin
              po_data   <= pay;
              po_valid  <= 1'b1;
              frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
              cnt       <= 6'd0;
              rx_busy   <= 1'b0;
              if (si_end) begin
                rx_done <= 1'b1;
                state   <= DONE;
              end else begin
                state   <= IDLE;
              end
            end else begin
              frame <= fr_nxt;
              cnt   <= cnt_nxt;
            end
          end else if (gap_nxt > TOL) begin
            frame_err <= 1'b1;
            cnt       <= 6'd0;
            gap       <= 5'd0;
            rx_busy   <= 1'b0;
            state     <= IDLE;
          end else begin
            gap <= gap_nxt;
          end
        end
        DONE: begin
          rx_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sti_rx_deser.sv
// Randomized self-checking bench for sti_rx_deser.
// Payload/pad/count expectations come from a frame-level model.
module tb_sti_rx_deser;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data, si_valid, si_end;
  logic [1:0]  cfg_length;
  logic        cfg_fill, cfg_msb, cfg_low;
  logic [15:0] po_data;
  logic        po_valid, frame_err, pad_err;
  logic        rx_busy, rx_done;
  logic [7:0]  frame_cnt;

  int n_asrt = 0;
  int n_fail = 0;
  int exp_cnt = 0;
  logic [15:0] last_data = 16'h0;

  always #5 clk = ~clk;

  sti_rx_deser #(.GAP_TOL(0), .FRAME_CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .si_data(si_data), .si_valid(si_valid), .si_end(si_end),
    .cfg_length(cfg_length), .cfg_fill(cfg_fill),
    .cfg_msb(cfg_msb), .cfg_low(cfg_low),
    .po_data(po_data), .po_valid(po_valid),
    .frame_err(frame_err), .pad_err(pad_err),
    .rx_busy(rx_busy), .rx_done(rx_done),
    .frame_cnt(frame_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_pay(
      input int L, input logic fill, input logic low,
      input logic [31:0] f);
    case (L)
      8:  return low ? 16'((f & 32'hFF) * 256) : 16'(f & 32'hFF);
      16: return 16'(f);
      24: return fill ? 16'(f >> 8) : 16'(f);
      default: return fill ? 16'(f >> 16) : 16'(f);
    endcase
  endfunction

  function automatic logic model_pad(
      input int L, input logic fill, input logic [31:0] f);
`ifdef STI_RX_PADCHK_EN
    if (L == 24) return fill ? ((f & 32'hFF) != 0)
                             : (((f >> 16) & 32'hFF) != 0);
    if (L == 32) return fill ? ((f & 32'hFFFF) != 0)
                             : ((f >> 16) != 0);
`endif
    return 1'b0;
  endfunction

  task automatic idle_cycles(input int n);
    si_valid = 1'b0;
    si_end   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Shifts a whole frame in with no gaps; cfg_* is scrambled after bit 1
  task automatic send(input logic [1:0] len, input logic fill,
                      input logic msb, input logic low,
                      input logic [31:0] f, input logic last);
    int L;
    logic [31:0] fm;
    L  = 8 * (int'(len) + 1);
    fm = (L == 32) ? f : (f & ((32'd1 << L) - 1));
    for (int i = 0; i < L; i++) begin
      if (i == 0) begin
        cfg_length = len; cfg_fill = fill;
        cfg_msb = msb; cfg_low = low;
      end else begin
        cfg_length = 2'($urandom); cfg_fill = 1'($urandom);
        cfg_msb = 1'($urandom); cfg_low = 1'($urandom);
      end
      si_valid = 1'b1;
      si_data  = msb ? fm[L-1-i] : fm[i];
      si_end   = (i == L-1) ? last : 1'($urandom);
      @(posedge clk); #1;
      if (i == 0) check("busy_first", 32'(rx_busy), 1);
      if (i < L-1) check("no_early_valid", 32'(po_valid), 0);
    end
    si_valid = 1'b0;
    si_end   = 1'b0;
    exp_cnt   = (exp_cnt + 1) % 256;
    last_data = model_pay(L, fill, low, fm);
    check("po_valid", 32'(po_valid), 1);
    check("po_data", 32'(po_data), 32'(last_data));
    check("pad_err", 32'(pad_err), 32'(model_pad(L, fill, fm)));
    check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("frame_err_quiet", 32'(frame_err), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {po_data, po_valid, frame_err, pad_err,
                rx_busy, rx_done, frame_cnt}, 0);
  endtask

  initial begin
    logic seen;
    reset = 1'b1;
    si_data = 0; si_valid = 0; si_end = 0;
    cfg_length = 0; cfg_fill = 0; cfg_msb = 0; cfg_low = 0;
    #23;
    check_all_zero("reset_state");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    send(2'd1, 0, 1, 0, 32'h0000_A5C3, 0);
    idle_cycles(1);
    check("po_valid_one_cycle", 32'(po_valid), 0);
    check("po_data_hold", 32'(po_data), 32'hA5C3);

    send(2'd0, 0, 0, 1, 32'h3C, 0);
    send(2'd0, 0, 0, 0, 32'h3C, 0);
    idle_cycles(2);

    send(2'd3, 0, 0, 0, 32'h0000_1234, 0);
    send(2'd2, 1, 1, 0, 32'h0056_7800, 0);
    idle_cycles(1);

    // Gap abort after bit 7
    cfg_length = 2'd1; cfg_msb = 1'b1;
    for (int i = 0; i < 7; i++) begin
      si_valid = 1'b1; si_data = 1'b1;
      @(posedge clk); #1;
    end
    si_valid = 1'b0;
    @(posedge clk); #1;
    check("gap_frame_err", 32'(frame_err), 1);
    check("gap_no_valid", 32'(po_valid), 0);
    check("gap_busy_clr", 32'(rx_busy), 0);
    check("gap_cnt_same", 32'(frame_cnt), 32'(exp_cnt));
    idle_cycles(1);
    check("gap_err_pulse", 32'(frame_err), 0);
    check("gap_data_hold", 32'(po_data), 32'(last_data));
    send(2'd1, 0, 1, 0, 32'h0000_0F0F, 0);

    for (int k = 0; k < 40; k++) begin
      send(2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), $urandom, 0);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // Enough short frames to carry frame_cnt through its wrap
    for (int k = 0; k < 230; k++)
      send(2'd0, 1'($urandom), 1'($urandom),
           1'($urandom), $urandom, 0);
    idle_cycles(1);

    // Reset at bit 10 of a 16-bit frame
    cfg_length = 2'd1; cfg_msb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      si_valid = 1'b1; si_data = 1'($urandom);
      @(posedge clk); #1;
    end
    si_valid = 1'b0;
    reset = 1'b1;
    #2;
    check_all_zero("reset_midframe");
    @(negedge clk); reset = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    send(2'd1, 0, 0, 0, 32'h0000_C0DE, 0);
    check("post_reset_cnt", 32'(frame_cnt), 1);

    send(2'd3, 0, 0, 0, 32'h0001_BEEF, 1);
    check("rx_done_set", 32'(rx_done), 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      si_valid = 1'b1; si_data = 1'($urandom);
      cfg_length = 2'($urandom);
      @(posedge clk); #1;
      seen = seen | po_valid | frame_err | rx_busy;
    end
    si_valid = 1'b0;
    check("done_ignores_bits", 32'(seen), 0);
    check("done_cnt_same", 32'(frame_cnt), 32'(exp_cnt));
    check("done_sticky", 32'(rx_done), 1);
    check("done_data_hold", 32'(po_data), 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
